// File: rtl/dmem_bridge_if.sv
// rtl/dmem_bridge_if.sv - req/ack data-bus bundle between the M-stage bridge and data memory
interface dmem_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - M-stage load/store bridge onto a variable-latency req/ack data bus
module dmem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    input  logic [31:0]   ALUOutM,
    input  logic [31:0]   WriteDataM,
    output logic [31:0]   ReadDataM,
    output logic          MemStallM,
    output logic          MemFaultM,
    dmem_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;

    logic access;
    logic aligned;

    assign access  = MemReadM | MemWriteM;
    assign aligned = (ALUOutM[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
            rdata_q <= 32'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        addr_d  = ALUOutM;
                        wdata_d = WriteDataM;
                        we_d    = MemWriteM;
                        cnt_d   = 8'd0;
                        fault_d = 1'b0;
                        state_d = BUSY;
                    end else begin
                        // Misaligned: skip the bus entirely; a write wins when both requests are high
                        fault_d = 1'b1;
                        if (!MemWriteM) begin
                            rdata_d = 32'd0;
                        end
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                if (bus.bus_ack) begin
                    if (!we_q) begin
                        rdata_d = bus.bus_rdata;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = 32'd0;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                fault_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Stall covers the IDLE cycle that sees the request plus every BUSY cycle
    assign MemStallM = ((state_q == IDLE) && access) || (state_q == BUSY);
    assign MemFaultM = (state_q == DONE) && fault_q;
    assign ReadDataM = rdata_q;

    assign bus.bus_req   = (state_q == BUSY);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed self-checking bench for dmem_bridge
module tb_dmem_bridge;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemStallM;
    logic        MemFaultM;

    dmem_bridge_if bif ();

    dmem_bridge #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .MemStallM  (MemStallM),
        .MemFaultM  (MemFaultM),
        .bus        (bif)
    );

    int passes = 0;
    int total  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Presents one access, acks it in BUSY cycle k (k<0: never), checks the whole transaction
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int k, input logic [31:0] rval,
                          input int exp_stall, input int exp_busy,
                          input logic exp_fault, input logic [31:0] exp_rdata);
        int stalls = 0;
        int busy   = 0;
        int iter   = 0;
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUOutM    = addr;
        WriteDataM = wd;
        #1;
        while (MemStallM === 1'b1 && iter < 20) begin
            stalls++;
            if (bif.bus_req === 1'b1) begin
                chk({tag, " bus_addr"},  bif.bus_addr,  addr);
                chk({tag, " bus_we"},    32'(bif.bus_we), 32'(wr));
                chk({tag, " bus_wdata"}, bif.bus_wdata, wd);
                bif.bus_ack   = (busy == k);
                bif.bus_rdata = rval;
                busy++;
            end
            tick();
            bif.bus_ack   = 1'b0;
            bif.bus_rdata = 32'h0;
            #1;
            iter++;
        end
        chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_stall));
        chk({tag, " bus_req cycles"}, 32'(busy), 32'(exp_busy));
        chk({tag, " DONE bus_req"}, 32'(bif.bus_req), 32'd0);
        chk({tag, " DONE fault"}, 32'(MemFaultM), 32'(exp_fault));
        chk({tag, " ReadDataM"}, ReadDataM, exp_rdata);
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        tick();
        chk({tag, " IDLE stall"}, 32'(MemStallM), 32'd0);
        chk({tag, " IDLE fault"}, 32'(MemFaultM), 32'd0);
        chk({tag, " IDLE ReadDataM"}, ReadDataM, exp_rdata);
        if (addr[1:0] == 2'b00) begin
            chk({tag, " held bus_addr"}, bif.bus_addr, addr);
        end
    endtask

    initial begin
        reset         = 1'b1;
        MemReadM      = 1'b0;
        MemWriteM     = 1'b0;
        ALUOutM       = 32'h0;
        WriteDataM    = 32'h0;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset ReadDataM", ReadDataM, 32'h0);
        chk("reset MemFaultM", 32'(MemFaultM), 32'd0);
        chk("reset MemStallM", 32'(MemStallM), 32'd0);
        chk("reset bus_req",   32'(bif.bus_req), 32'd0);
        chk("reset bus_we",    32'(bif.bus_we), 32'd0);
        chk("reset bus_addr",  bif.bus_addr, 32'h0);
        chk("reset bus_wdata", bif.bus_wdata, 32'h0);
        tick();

        access("load0", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF,
               2, 1, 1'b0, 32'hDEAD_BEEF);
        access("store", 1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 3, 32'hFFFF_FFFF,
               5, 4, 1'b0, 32'hDEAD_BEEF);
        access("misalign", 1'b1, 1'b0, 32'h0000_0102, 32'h0, 0, 32'h0,
               1, 0, 1'b1, 32'h0);
        chk("misalign keeps bus_addr", bif.bus_addr, 32'h0000_0204);
        access("load1", 1'b1, 1'b0, 32'h0000_0008, 32'h0, 2, 32'hA5A5_5A5A,
               4, 3, 1'b0, 32'hA5A5_5A5A);
        access("timeout", 1'b1, 1'b0, 32'h0000_0300, 32'h0, -1, 32'h0,
               5, 4, 1'b1, 32'h0);
        access("both", 1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1, 32'h7777_7777,
               3, 2, 1'b0, 32'h0);
        access("b2b0", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 0, 32'h1111_1111,
               2, 1, 1'b0, 32'h1111_1111);
        access("b2b1", 1'b1, 1'b0, 32'h0000_0004, 32'h0, 0, 32'h2222_2222,
               2, 1, 1'b0, 32'h2222_2222);

        // Reset in the second BUSY cycle of a slow load, then a stray late ack
        MemReadM = 1'b1;
        ALUOutM  = 32'h0000_0400;
        tick();
        chk("rst busy1 bus_req", 32'(bif.bus_req), 32'd1);
        tick();
        chk("rst busy2 bus_req", 32'(bif.bus_req), 32'd1);
        reset    = 1'b1;
        MemReadM = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rst after bus_req",   32'(bif.bus_req), 32'd0);
        chk("rst after MemStallM", 32'(MemStallM), 32'd0);
        chk("rst after ReadDataM", ReadDataM, 32'h0);
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'hBAD0_BAD0;
        tick();
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 32'h0;
        #1;
        chk("late ack ReadDataM", ReadDataM, 32'h0);
        chk("late ack MemFaultM", 32'(MemFaultM), 32'd0);
        chk("late ack bus_req",   32'(bif.bus_req), 32'd0);
        tick();
        chk("late ack+1 ReadDataM", ReadDataM, 32'h0);
        chk("late ack+1 MemFaultM", 32'(MemFaultM), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
